// File: rtl/uart_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module : uart_apb_sequencer
// Brief  : APB3 master that configures a CoreUARTapb, then polls STATUS and
//          moves bytes between fabric byte streams and TXDATA/RXDATA.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_apb_sequencer #(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] M_PADDR,
    output logic       M_PSEL,
    output logic       M_PENABLE,
    output logic       M_PWRITE,
    output logic [7:0] M_PWDATA,
    input  logic [7:0] M_PRDATA,
    input  logic       M_PREADY,
    input  logic       M_PSLVERR,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       cfg_done,
    output logic       err_parity,
    output logic       err_overflow,
    output logic       err_framing,
    output logic       err_apb
);

    localparam logic [4:0] c_addr_txdata = 5'h00;
    localparam logic [4:0] c_addr_rxdata = 5'h04;
    localparam logic [4:0] c_addr_ctrl1  = 5'h08;
    localparam logic [4:0] c_addr_ctrl2  = 5'h0C;
    localparam logic [4:0] c_addr_status = 5'h10;
    localparam logic [7:0] c_ctrl1_val   = BAUD_VALUE[7:0];
    localparam logic [7:0] c_ctrl2_val   = {BAUD_VALUE[12:8], PARITY_ODD, PARITY_EN, BIT8};

    typedef enum logic [2:0] {
        S_CFG1   = 3'd0,
        S_CFG2   = 3'd1,
        S_POLL   = 3'd2,
        S_DECIDE = 3'd3,
        S_RXRD   = 3'd4,
        S_TXWR   = 3'd5
    } state_t;

    state_t     r_state,        w_state_nxt;
    logic       r_psel,         w_psel_nxt;
    logic       r_penable,      w_penable_nxt;
    logic [4:0] r_paddr,        w_paddr_nxt;
    logic       r_pwrite,       w_pwrite_nxt;
    logic [7:0] r_pwdata,       w_pwdata_nxt;
    logic       r_retry,        w_retry_nxt;
    logic [1:0] r_status,       w_status_nxt;
    logic       r_rr_tx_first,  w_rr_tx_first_nxt;
    logic [7:0] r_rx_data,      w_rx_data_nxt;
    logic       r_rx_valid,     w_rx_valid_nxt;
    logic       r_cfg_done,     w_cfg_done_nxt;
    logic       r_err_parity,   w_err_parity_nxt;
    logic       r_err_overflow, w_err_overflow_nxt;
    logic       r_err_framing,  w_err_framing_nxt;
    logic       r_err_apb,      w_err_apb_nxt;

    logic       w_done;
    logic       w_rx_ok;
    logic       w_tx_ok;
    logic       w_tx_grant;
    logic       w_launch;
    logic [4:0] w_l_addr;
    logic       w_l_write;
    logic [7:0] w_l_data;

    assign w_done  = r_psel & r_penable & M_PREADY;
    assign w_rx_ok = r_status[1] & ~r_rx_valid;
    assign w_tx_ok = r_status[0] & tx_valid;

    always_comb begin
        w_state_nxt        = r_state;
        w_psel_nxt         = r_psel;
        w_penable_nxt      = r_penable;
        w_paddr_nxt        = r_paddr;
        w_pwrite_nxt       = r_pwrite;
        w_pwdata_nxt       = r_pwdata;
        w_retry_nxt        = r_retry;
        w_status_nxt       = r_status;
        w_rr_tx_first_nxt  = r_rr_tx_first;
        w_rx_data_nxt      = r_rx_data;
        w_rx_valid_nxt     = r_rx_valid;
        w_cfg_done_nxt     = r_cfg_done;
        w_err_parity_nxt   = r_err_parity;
        w_err_overflow_nxt = r_err_overflow;
        w_err_framing_nxt  = r_err_framing;
        w_err_apb_nxt      = r_err_apb;
        w_tx_grant         = 1'b0;
        w_launch           = 1'b0;
        w_l_addr           = r_paddr;
        w_l_write          = 1'b0;
        w_l_data           = r_pwdata;

        if (r_psel && !r_penable) begin
            w_penable_nxt = 1'b1;
        end else if (w_done) begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
        end

        if (r_rx_valid && rx_ready) begin
            w_rx_valid_nxt = 1'b0;
        end

        // Clear first so that a flag raised in the same cycle survives err_clr.
        if (err_clr) begin
            w_err_parity_nxt   = 1'b0;
            w_err_overflow_nxt = 1'b0;
            w_err_framing_nxt  = 1'b0;
            w_err_apb_nxt      = 1'b0;
        end
        if (w_done && M_PSLVERR) begin
            w_err_apb_nxt = 1'b1;
        end
        if (w_done && r_state == S_POLL) begin
            w_err_parity_nxt   = w_err_parity_nxt   | M_PRDATA[2];
            w_err_overflow_nxt = w_err_overflow_nxt | M_PRDATA[3];
            w_err_framing_nxt  = w_err_framing_nxt  | M_PRDATA[4];
        end

        case (r_state)
            S_CFG1, S_CFG2: begin
                if (!r_psel) begin
                    w_launch  = 1'b1;
                    w_l_write = 1'b1;
                    w_l_addr  = (r_state == S_CFG1) ? c_addr_ctrl1 : c_addr_ctrl2;
                    w_l_data  = (r_state == S_CFG1) ? c_ctrl1_val  : c_ctrl2_val;
                end else if (w_done) begin
                    // A failed config write gets one more attempt before moving on.
                    if (M_PSLVERR && !r_retry) begin
                        w_retry_nxt = 1'b1;
                    end else begin
                        w_retry_nxt = 1'b0;
                        if (r_state == S_CFG1) begin
                            w_state_nxt = S_CFG2;
                        end else begin
                            w_state_nxt    = S_POLL;
                            w_cfg_done_nxt = 1'b1;
                        end
                    end
                end
            end
            S_POLL: begin
                if (!r_psel) begin
                    w_launch = 1'b1;
                    w_l_addr = c_addr_status;
                end else if (w_done) begin
                    w_status_nxt = M_PRDATA[1:0];
                    w_state_nxt  = S_DECIDE;
                end
            end
            S_DECIDE: begin
                w_launch = 1'b1;
                if (w_rx_ok && (!w_tx_ok || !r_rr_tx_first)) begin
                    w_l_addr    = c_addr_rxdata;
                    w_state_nxt = S_RXRD;
                    if (w_tx_ok) begin
                        w_rr_tx_first_nxt = 1'b1;
                    end
                end else if (w_tx_ok) begin
                    w_tx_grant  = 1'b1;
                    w_l_addr    = c_addr_txdata;
                    w_l_write   = 1'b1;
                    w_l_data    = tx_data;
                    w_state_nxt = S_TXWR;
                    if (w_rx_ok) begin
                        w_rr_tx_first_nxt = 1'b0;
                    end
                end else begin
                    w_l_addr    = c_addr_status;
                    w_state_nxt = S_POLL;
                end
            end
            S_RXRD: begin
                if (w_done) begin
                    if (!M_PSLVERR) begin
                        w_rx_data_nxt  = M_PRDATA;
                        w_rx_valid_nxt = 1'b1;
                    end
                    w_state_nxt = S_POLL;
                end
            end
            S_TXWR: begin
                if (w_done) begin
                    w_state_nxt = S_POLL;
                end
            end
            default: begin
                w_state_nxt = S_CFG1;
            end
        endcase

        if (w_launch) begin
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
            w_paddr_nxt   = w_l_addr;
            w_pwrite_nxt  = w_l_write;
            w_pwdata_nxt  = w_l_data;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state        <= S_CFG1;
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_paddr        <= 5'h00;
            r_pwrite       <= 1'b0;
            r_pwdata       <= 8'h00;
            r_retry        <= 1'b0;
            r_status       <= 2'b00;
            r_rr_tx_first  <= 1'b0;
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_cfg_done     <= 1'b0;
            r_err_parity   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_framing  <= 1'b0;
            r_err_apb      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_psel         <= w_psel_nxt;
            r_penable      <= w_penable_nxt;
            r_paddr        <= w_paddr_nxt;
            r_pwrite       <= w_pwrite_nxt;
            r_pwdata       <= w_pwdata_nxt;
            r_retry        <= w_retry_nxt;
            r_status       <= w_status_nxt;
            r_rr_tx_first  <= w_rr_tx_first_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid     <= w_rx_valid_nxt;
            r_cfg_done     <= w_cfg_done_nxt;
            r_err_parity   <= w_err_parity_nxt;
            r_err_overflow <= w_err_overflow_nxt;
            r_err_framing  <= w_err_framing_nxt;
            r_err_apb      <= w_err_apb_nxt;
        end
    end

    assign M_PADDR      = r_paddr;
    assign M_PSEL       = r_psel;
    assign M_PENABLE    = r_penable;
    assign M_PWRITE     = r_pwrite;
    assign M_PWDATA     = r_pwdata;
    assign tx_ready     = w_tx_grant;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign cfg_done     = r_cfg_done;
    assign err_parity   = r_err_parity;
    assign err_overflow = r_err_overflow;
    assign err_framing  = r_err_framing;
    assign err_apb      = r_err_apb;

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_apb_sequencer
// Brief  : Scoreboard bench: APB slave model serves STATUS/RXDATA and checks
//          every completed access against queued expectations.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_apb_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic [4:0] M_PADDR;
    logic       M_PSEL, M_PENABLE, M_PWRITE;
    logic [7:0] M_PWDATA;
    logic [7:0] M_PRDATA = 8'h00;
    logic       M_PREADY = 1'b0;
    logic       M_PSLVERR = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       err_clr;
    logic       tb_clr = 1'b0;
    logic       sl_clr = 1'b0;
    logic       cfg_done, err_parity, err_overflow, err_framing, err_apb;

    assign err_clr = tb_clr | sl_clr;

    uart_apb_sequencer #(
        .BAUD_VALUE (13'h1A5),
        .BIT8       (1'b1),
        .PARITY_EN  (1'b0),
        .PARITY_ODD (1'b1)
    ) dut (
        .PCLK         (PCLK),
        .PRESETN      (PRESETN),
        .M_PADDR      (M_PADDR),
        .M_PSEL       (M_PSEL),
        .M_PENABLE    (M_PENABLE),
        .M_PWRITE     (M_PWRITE),
        .M_PWDATA     (M_PWDATA),
        .M_PRDATA     (M_PRDATA),
        .M_PREADY     (M_PREADY),
        .M_PSLVERR    (M_PSLVERR),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .err_clr      (err_clr),
        .cfg_done     (cfg_done),
        .err_parity   (err_parity),
        .err_overflow (err_overflow),
        .err_framing  (err_framing),
        .err_apb      (err_apb)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
    } apb_t;

    apb_t       exp_q[$];
    logic [7:0] status_q[$];
    logic [7:0] rx_exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cfg1_err = 0;
    int         poll_wait = 0;
    int         wait_cnt = 0;
    int         acc_len = 0;
    int         last_poll_len = 0;
    int         tx_cnt = 0;
    logic [7:0] rxdata_val = 8'h00;
    logic       clr_with_status = 1'b0;
    apb_t       got;
    logic [7:0] st;
    logic [7:0] rx_e;

    function automatic apb_t mk(input logic wr, input logic [4:0] a, input logic [7:0] d);
        return {wr, a, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_apb(input apb_t g);
        apb_t e;
        if (exp_q.size() == 0) begin
            // Idle STATUS polls are free-running and need no expectation.
            if (g.wr || g.addr != 5'h10) begin
                checks++;
                errors++;
                $display("FAIL apb_unexpected: actual wr=%0b addr=0x%0h data=0x%0h required none",
                         g.wr, g.addr, g.data);
            end
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (g.wr !== e.wr || g.addr !== e.addr || (e.wr && g.data !== e.data)) begin
                errors++;
                $display("FAIL apb_xfer: actual wr=%0b addr=0x%0h data=0x%0h required wr=%0b addr=0x%0h data=0x%0h",
                         g.wr, g.addr, g.data, e.wr, e.addr, e.data);
            end
        end
    endtask

    // APB slave model and transaction monitor
    always @(negedge PCLK) begin
        M_PREADY  = 1'b0;
        M_PSLVERR = 1'b0;
        sl_clr    = 1'b0;
        if (M_PSEL && M_PENABLE) begin
            acc_len++;
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else begin
                M_PREADY = 1'b1;
                got = {M_PWRITE, M_PADDR, M_PWDATA};
                if (!M_PWRITE && M_PADDR == 5'h10) begin
                    st = 8'h00;
                    if (status_q.size() > 0) begin
                        st = status_q.pop_front();
                        if (clr_with_status) begin
                            sl_clr = 1'b1;
                            clr_with_status = 1'b0;
                        end
                    end
                    M_PRDATA = st;
                    last_poll_len = acc_len;
                end else if (!M_PWRITE && M_PADDR == 5'h04) begin
                    M_PRDATA = rxdata_val;
                end else begin
                    M_PRDATA = 8'h00;
                end
                if (M_PWRITE && M_PADDR == 5'h08 && cfg1_err > 0) begin
                    M_PSLVERR = 1'b1;
                    cfg1_err--;
                end
                check_apb(got);
            end
        end else begin
            acc_len = 0;
            if (M_PSEL && !M_PWRITE && M_PADDR == 5'h10) wait_cnt = poll_wait;
            else wait_cnt = 0;
        end
    end

    // RX stream monitor
    always @(negedge PCLK) begin
        if (tx_ready) tx_cnt++;
        if (rx_valid && rx_ready) begin
            if (rx_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: actual=0x%0h required none", rx_data);
            end else begin
                rx_e = rx_exp_q.pop_front();
                chk("rx_byte", {24'h0, rx_data}, {24'h0, rx_e});
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || status_q.size() != 0) && n < 400) begin
            @(posedge PCLK);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual pending=%0d required 0", exp_q.size());
            exp_q.delete();
            status_q.delete();
        end
        repeat (4) @(posedge PCLK);
        #1;
    endtask

    task automatic accept_tx();
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge PCLK);
            if (tx_ready) break;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL tx_accept_timeout: actual tx_ready=0 required 1");
        end
        @(posedge PCLK);
        #1 tx_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel",     {31'h0, M_PSEL},    0);
        chk("rst_penable",  {31'h0, M_PENABLE}, 0);
        chk("rst_paddr",    {27'h0, M_PADDR},   0);
        chk("rst_pwdata",   {24'h0, M_PWDATA},  0);
        chk("rst_cfg_done", {31'h0, cfg_done},  0);
        chk("rst_rx_valid", {31'h0, rx_valid},  0);
        chk("rst_tx_ready", {31'h0, tx_ready},  0);
        chk("rst_errs", {28'h0, err_parity, err_overflow, err_framing, err_apb}, 0);

        // T1: configuration writes then first poll
        exp_q.push_back(mk(1'b1, 5'h08, 8'hA5));
        exp_q.push_back(mk(1'b1, 5'h0C, 8'h0D));
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        PRESETN = 1'b1;
        drain();
        chk("t1_cfg_done", {31'h0, cfg_done}, 1);

        // T2: TX only
        tx_data = 8'h55;
        tx_valid = 1'b1;
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        exp_q.push_back(mk(1'b1, 5'h00, 8'h55));
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        status_q.push_back(8'h01);
        accept_tx();
        drain();
        chk("t2_tx_cnt", tx_cnt, 1);

        // T3: both ready, RX first then alternation to TX
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        rxdata_val = 8'h81;
        rx_exp_q.push_back(8'h81);
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        exp_q.push_back(mk(1'b0, 5'h04, 8'h00));
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        exp_q.push_back(mk(1'b1, 5'h00, 8'hAA));
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        status_q.push_back(8'h03);
        status_q.push_back(8'h03);
        accept_tx();
        drain();
        chk("t3_tx_cnt", tx_cnt, 2);
        chk("t3_rx_drained", rx_exp_q.size(), 0);

        // T4: consumer stalls, byte held and no further RXDATA reads
        rx_ready = 1'b0;
        rxdata_val = 8'h3C;
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        exp_q.push_back(mk(1'b0, 5'h04, 8'h00));
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        status_q.push_back(8'h02);
        status_q.push_back(8'h02);
        status_q.push_back(8'h02);
        drain();
        repeat (20) @(posedge PCLK);
        #1;
        chk("t4_rx_valid", {31'h0, rx_valid}, 1);
        chk("t4_rx_data", {24'h0, rx_data}, 32'h3C);
        rx_exp_q.push_back(8'h3C);
        rx_ready = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("t4_rx_taken", rx_exp_q.size(), 0);
        chk("t4_rx_valid_clr", {31'h0, rx_valid}, 0);
        chk("t4_no_errs", {29'h0, err_parity, err_overflow, err_framing}, 0);

        // T5: line errors captured in the same cycle as err_clr stay set
        clr_with_status = 1'b1;
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        status_q.push_back(8'h1C);
        drain();
        chk("t5_err_parity",   {31'h0, err_parity},   1);
        chk("t5_err_overflow", {31'h0, err_overflow}, 1);
        chk("t5_err_framing",  {31'h0, err_framing},  1);
        chk("t5_err_apb",      {31'h0, err_apb},      0);
        tb_clr = 1'b1;
        @(posedge PCLK);
        #1 tb_clr = 1'b0;
        chk("t5_errs_cleared", {29'h0, err_parity, err_overflow, err_framing}, 0);

        // T6: async reset mid-access, CTRL1 errors, wait states on STATUS
        begin
            int n;
            n = 0;
            while (!(M_PSEL && M_PENABLE) && n < 100) begin
                @(negedge PCLK);
                n++;
            end
        end
        #2 PRESETN = 1'b0;
        #1;
        chk("t6_rst_psel",    {31'h0, M_PSEL},    0);
        chk("t6_rst_penable", {31'h0, M_PENABLE}, 0);
        chk("t6_rst_cfg",     {31'h0, cfg_done},  0);
        cfg1_err  = 2;
        poll_wait = 5;
        exp_q.push_back(mk(1'b1, 5'h08, 8'hA5));
        exp_q.push_back(mk(1'b1, 5'h08, 8'hA5));
        exp_q.push_back(mk(1'b1, 5'h0C, 8'h0D));
        exp_q.push_back(mk(1'b0, 5'h10, 8'h00));
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        drain();
        chk("t6_cfg_done", {31'h0, cfg_done}, 1);
        chk("t6_err_apb", {31'h0, err_apb}, 1);
        chk("t6_poll_len", last_poll_len, 6);
        chk("t6_tx_cnt", tx_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
